// File: rtl/control_pipe.sv
// ----------------------------------------------------------------------------
// control_pipe
//   Pipelined MIPS control unit. Decodes opcode/funct in ID, carries the
//   EX/MEM/WB control bundles through stage registers, detects load-use
//   hazards and inserts LOAD_STALL_CYC bubbles, raises the IF flush for
//   J / JR / taken BGT, and freezes every stage while data memory is busy.
//
//   Optional feature macro: CTRL_PERF_EN
//     When defined, adds saturating perf counters perf_stall_cnt and
//     perf_flush_cnt (PERF_W bits each). When undefined they are absent.
//
//   Ports
//     clk, rst_n       clock, asynchronous active-low reset
//     opcode_id        opcode of instruction in ID
//     funct_id         funct field of instruction in ID
//     rs_id, rt_id     source register numbers in ID
//     bgt_taken_id     BGT comparison result in ID
//     mem_busy         data memory not ready; freeze the pipe
//     stall            hold PC and IF/ID register
//     if_flush         squash instruction in IF
//     jump_id          J taken
//     jr_id            JR taken
//     branch_id        BGT decoded
//     ex_alu_op        ALUOp in EX
//     ex_alu_src       ALUSrc in EX
//     ex_reg_dst       RegDst in EX
//     mem_mem_read     MemRead in MEM
//     mem_mem_write    MemWrite in MEM
//     wb_reg_write     RegWrite in WB
//     wb_mem_to_reg    MemtoReg in WB
//     perf_stall_cnt   hazard-bubble cycles (CTRL_PERF_EN only)
//     perf_flush_cnt   if_flush cycles (CTRL_PERF_EN only)
// ----------------------------------------------------------------------------
module control_pipe #(
    parameter int OPW            = 6,
    parameter int FNW            = 6,
    parameter int RAW            = 5,
    parameter int LOAD_STALL_CYC = 1,
    parameter int PERF_W         = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [OPW-1:0] opcode_id,
    input  logic [FNW-1:0] funct_id,
    input  logic [RAW-1:0] rs_id,
    input  logic [RAW-1:0] rt_id,
    input  logic           bgt_taken_id,
    input  logic           mem_busy,
    output logic           stall,
    output logic           if_flush,
    output logic           jump_id,
    output logic           jr_id,
    output logic           branch_id,
    output logic [1:0]     ex_alu_op,
    output logic           ex_alu_src,
    output logic           ex_reg_dst,
    output logic           mem_mem_read,
    output logic           mem_mem_write,
    output logic           wb_reg_write,
    output logic           wb_mem_to_reg
`ifdef CTRL_PERF_EN
    ,
    output logic [PERF_W-1:0] perf_stall_cnt,
    output logic [PERF_W-1:0] perf_flush_cnt
`endif
);

    // ------------------------------------------------------------------
    // Encodings
    // ------------------------------------------------------------------
    localparam logic [OPW-1:0] OP_RTYPE = OPW'(6'b000000);
    localparam logic [OPW-1:0] OP_ADDI  = OPW'(6'b001000);
    localparam logic [OPW-1:0] OP_LW    = OPW'(6'b100011);
    localparam logic [OPW-1:0] OP_SW    = OPW'(6'b101011);
    localparam logic [OPW-1:0] OP_BGT   = OPW'(6'b000111);
    localparam logic [OPW-1:0] OP_J     = OPW'(6'b000010);
    localparam logic [FNW-1:0] FN_JR    = FNW'(6'b001000);

    // Bubble countdown preload; the hazard cycle itself is the first bubble.
    localparam logic [1:0] CNT_LOAD = 2'(LOAD_STALL_CYC - 1);

    // ------------------------------------------------------------------
    // Control bundles. Each stage keeps only the fields still needed
    // downstream of it.
    // ------------------------------------------------------------------
    typedef struct packed {
        logic [1:0] alu_op;
        logic       alu_src;
        logic       reg_dst;
    } ex_ctl_t;

    typedef struct packed {
        logic mem_read;
        logic mem_write;
    } mem_ctl_t;

    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
    } wb_ctl_t;

    typedef struct packed {
        ex_ctl_t  ex;
        mem_ctl_t mem;
        wb_ctl_t  wb;
    } ctrl_t;

    typedef struct packed {
        mem_ctl_t mem;
        wb_ctl_t  wb;
    } mem_stage_t;

    localparam ex_ctl_t  EX_NOP  = '{alu_op: 2'b11, alu_src: 1'b0, reg_dst: 1'b0};
    localparam mem_ctl_t MEM_NOP = '{mem_read: 1'b0, mem_write: 1'b0};
    localparam wb_ctl_t  WB_NOP  = '{reg_write: 1'b0, mem_to_reg: 1'b0};
    localparam ctrl_t    CTRL_NOP = '{ex: EX_NOP, mem: MEM_NOP, wb: WB_NOP};
    localparam mem_stage_t MEMST_NOP = '{mem: MEM_NOP, wb: WB_NOP};

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    ctrl_t          ex_q,    ex_d;
    logic [RAW-1:0] ex_rt_q, ex_rt_d;
    mem_stage_t     mem_q,   mem_d;
    wb_ctl_t        wb_q,    wb_d;
    logic [1:0]     cnt_q,   cnt_d;

    // ------------------------------------------------------------------
    // ID decode
    // ------------------------------------------------------------------
    ctrl_t dec;
    logic  dec_j;
    logic  dec_jr;
    logic  dec_bgt;

    always_comb begin
        dec     = CTRL_NOP;
        dec_j   = 1'b0;
        dec_jr  = 1'b0;
        dec_bgt = 1'b0;
        case (opcode_id)
            OP_RTYPE: begin
                dec.ex.alu_op    = 2'b10;
                dec.ex.reg_dst   = 1'b1;
                // JR shares the R-type bundle but writes no register.
                dec_jr           = (funct_id == FN_JR);
                dec.wb.reg_write = (funct_id != FN_JR);
            end
            OP_ADDI: begin
                dec.ex.alu_op    = 2'b00;
                dec.ex.alu_src   = 1'b1;
                dec.wb.reg_write = 1'b1;
            end
            OP_LW: begin
                dec.ex.alu_op     = 2'b00;
                dec.ex.alu_src    = 1'b1;
                dec.mem.mem_read  = 1'b1;
                dec.wb.mem_to_reg = 1'b1;
                dec.wb.reg_write  = 1'b1;
            end
            OP_SW: begin
                dec.ex.alu_op     = 2'b00;
                dec.ex.alu_src    = 1'b1;
                dec.mem.mem_write = 1'b1;
            end
            OP_BGT: begin
                dec.ex.alu_op = 2'b01;
                dec_bgt       = 1'b1;
            end
            OP_J: begin
                dec.ex.alu_op = 2'b11;
                dec_j         = 1'b1;
            end
            default: begin
                dec = CTRL_NOP;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Hazard detection and stall / flush generation
    // ------------------------------------------------------------------
    logic haz;
    logic bubble;

    assign haz = ex_q.mem.mem_read && (ex_rt_q != '0) &&
                 ((ex_rt_q == rs_id) || (ex_rt_q == rt_id));

    // A bubble is inserted on the hazard cycle and on every cycle the
    // countdown is still running.
    assign bubble = haz || (cnt_q != '0);

    assign stall     = bubble || mem_busy;
    assign jump_id   = dec_j   && !stall;
    assign jr_id     = dec_jr  && !stall;
    assign branch_id = dec_bgt && !stall;
    assign if_flush  = jump_id || jr_id || (branch_id && bgt_taken_id);

    // ------------------------------------------------------------------
    // Stage advance. mem_busy freezes everything, including the bubble
    // countdown, so a pending hazard is simply re-seen after release.
    // ------------------------------------------------------------------
    always_comb begin
        ex_d    = ex_q;
        ex_rt_d = ex_rt_q;
        mem_d   = mem_q;
        wb_d    = wb_q;
        cnt_d   = cnt_q;
        if (!mem_busy) begin
            wb_d      = mem_q.wb;
            mem_d.mem = ex_q.mem;
            mem_d.wb  = ex_q.wb;
            if (bubble) begin
                ex_d    = CTRL_NOP;
                ex_rt_d = '0;
            end else begin
                ex_d    = dec;
                ex_rt_d = rt_id;
            end
            if (cnt_q != '0) begin
                cnt_d = cnt_q - 2'd1;
            end else if (haz) begin
                cnt_d = CNT_LOAD;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q    <= CTRL_NOP;
            ex_rt_q <= '0;
            mem_q   <= MEMST_NOP;
            wb_q    <= WB_NOP;
            cnt_q   <= '0;
        end else begin
            ex_q    <= ex_d;
            ex_rt_q <= ex_rt_d;
            mem_q   <= mem_d;
            wb_q    <= wb_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ex_alu_op     = ex_q.ex.alu_op;
    assign ex_alu_src    = ex_q.ex.alu_src;
    assign ex_reg_dst    = ex_q.ex.reg_dst;
    assign mem_mem_read  = mem_q.mem.mem_read;
    assign mem_mem_write = mem_q.mem.mem_write;
    assign wb_reg_write  = wb_q.reg_write;
    assign wb_mem_to_reg = wb_q.mem_to_reg;

    // ------------------------------------------------------------------
    // Optional saturating perf counters
    // ------------------------------------------------------------------
`ifdef CTRL_PERF_EN
    logic [PERF_W-1:0] perf_stall_q, perf_stall_d;
    logic [PERF_W-1:0] perf_flush_q, perf_flush_d;

    always_comb begin
        perf_stall_d = perf_stall_q;
        perf_flush_d = perf_flush_q;
        // Only hazard bubbles count; memory-busy freeze cycles do not.
        if (bubble && !mem_busy && (perf_stall_q != '1)) begin
            perf_stall_d = perf_stall_q + PERF_W'(1);
        end
        if (if_flush && (perf_flush_q != '1)) begin
            perf_flush_d = perf_flush_q + PERF_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            perf_stall_q <= perf_stall_d;
            perf_flush_q <= perf_flush_d;
        end
    end

    assign perf_stall_cnt = perf_stall_q;
    assign perf_flush_cnt = perf_flush_q;
`else
    localparam int unused_perf_w = PERF_W;
`endif

endmodule

// File: tb/tb_control_pipe.sv
module tb_control_pipe;

    localparam logic [5:0] O_R    = 6'b000000;
    localparam logic [5:0] O_ADDI = 6'b001000;
    localparam logic [5:0] O_LW   = 6'b100011;
    localparam logic [5:0] O_SW   = 6'b101011;
    localparam logic [5:0] O_BGT  = 6'b000111;
    localparam logic [5:0] O_J    = 6'b000010;
    localparam logic [5:0] O_BAD  = 6'b111111;
    localparam logic [5:0] F_ADD  = 6'b100000;
    localparam logic [5:0] F_JR   = 6'b001000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n = 1'b0;
    logic [5:0] opcode = O_BAD;
    logic [5:0] funct = '0;
    logic [4:0] rs = '0;
    logic [4:0] rt = '0;
    logic       taken = 1'b0;
    logic       busy = 1'b0;
    logic       in_rst = 1'b1;

    logic       a_stall, a_flush, a_jump, a_jr, a_br, a_src, a_dst, a_mr, a_mw, a_rw, a_m2r;
    logic [1:0] a_alu;
    logic       b_stall, b_flush, b_jump, b_jr, b_br, b_src, b_dst, b_mr, b_mw, b_rw, b_m2r;
    logic [1:0] b_alu;
`ifdef CTRL_PERF_EN
    logic [1:0]  a_ps, a_pf;
    logic [15:0] b_ps, b_pf;
`endif

    logic [12:0] out_a, out_b;
    assign out_a = {a_stall, a_flush, a_jump, a_jr, a_br, a_alu, a_src, a_dst, a_mr, a_mw, a_rw, a_m2r};
    assign out_b = {b_stall, b_flush, b_jump, b_jr, b_br, b_alu, b_src, b_dst, b_mr, b_mw, b_rw, b_m2r};

    control_pipe #(.LOAD_STALL_CYC(1), .PERF_W(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .opcode_id(opcode), .funct_id(funct),
        .rs_id(rs), .rt_id(rt), .bgt_taken_id(taken), .mem_busy(busy),
        .stall(a_stall), .if_flush(a_flush), .jump_id(a_jump), .jr_id(a_jr),
        .branch_id(a_br), .ex_alu_op(a_alu), .ex_alu_src(a_src), .ex_reg_dst(a_dst),
        .mem_mem_read(a_mr), .mem_mem_write(a_mw), .wb_reg_write(a_rw),
        .wb_mem_to_reg(a_m2r)
`ifdef CTRL_PERF_EN
        , .perf_stall_cnt(a_ps), .perf_flush_cnt(a_pf)
`endif
    );

    control_pipe #(.LOAD_STALL_CYC(3), .PERF_W(16)) dut_b (
        .clk(clk), .rst_n(rst_n), .opcode_id(opcode), .funct_id(funct),
        .rs_id(rs), .rt_id(rt), .bgt_taken_id(taken), .mem_busy(busy),
        .stall(b_stall), .if_flush(b_flush), .jump_id(b_jump), .jr_id(b_jr),
        .branch_id(b_br), .ex_alu_op(b_alu), .ex_alu_src(b_src), .ex_reg_dst(b_dst),
        .mem_mem_read(b_mr), .mem_mem_write(b_mw), .wb_reg_write(b_rw),
        .wb_mem_to_reg(b_m2r)
`ifdef CTRL_PERF_EN
        , .perf_stall_cnt(b_ps), .perf_flush_cnt(b_pf)
`endif
    );

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    int n_cmp = 0;
    int n_bad = 0;
    string cur_tag = "init";

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s/%s: got %0h expected %0h at %0t", cur_tag, name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: full instruction bundle per stage, bubbles owed.
    // ------------------------------------------------------------------
    typedef struct packed {
        logic [1:0] alu;
        logic src, dst, mr, mw, rw, m2r;
    } bun_t;
    localparam bun_t BNOP = 8'b11_000000;

    typedef struct {
        bun_t       ex, mem, wb;
        logic [4:0] ex_rt;
        int         owed;
        int         ps, pf;
    } mst_t;

    typedef struct {
        logic [12:0] o;
        logic        bubble;
        int          owed;
    } ev_t;

    mst_t m[2];
    int   lsc[2] = '{1, 3};
    int   pmax[2] = '{3, 65535};

    function automatic bun_t ref_bundle(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            O_R:     return (fn == F_JR) ? 8'b10_010000 : 8'b10_010010;
            O_ADDI:  return 8'b00_100010;
            O_LW:    return 8'b00_101011;
            O_SW:    return 8'b00_100100;
            O_BGT:   return 8'b01_000000;
            default: return BNOP;
        endcase
    endfunction

    // {jump, jr, branch}
    function automatic logic [2:0] ref_kind(input logic [5:0] op, input logic [5:0] fn);
        if (op == O_J) return 3'b100;
        if (op == O_R && fn == F_JR) return 3'b010;
        if (op == O_BGT) return 3'b001;
        return 3'b000;
    endfunction

    function automatic void model_reset(input int k);
        m[k].ex = BNOP; m[k].mem = BNOP; m[k].wb = BNOP;
        m[k].ex_rt = '0; m[k].owed = 0; m[k].ps = 0; m[k].pf = 0;
    endfunction

    function automatic ev_t ref_eval(input int k);
        ev_t        r;
        logic       haz, stl, fl;
        logic [2:0] kd;
        haz = m[k].ex.mr && (m[k].ex_rt != 5'd0) && (m[k].ex_rt == rs || m[k].ex_rt == rt);
        r.owed = (haz && m[k].owed == 0) ? lsc[k] : m[k].owed;
        stl = busy || (r.owed > 0);
        r.bubble = !busy && (r.owed > 0);
        kd = stl ? 3'b000 : ref_kind(opcode, funct);
        fl = kd[2] || kd[1] || (kd[0] && taken);
        r.o = {stl, fl, kd, m[k].ex.alu, m[k].ex.src, m[k].ex.dst,
               m[k].mem.mr, m[k].mem.mw, m[k].wb.rw, m[k].wb.m2r};
        return r;
    endfunction

    function automatic void model_advance(input int k);
        ev_t r;
        if (busy) return;
        r = ref_eval(k);
        m[k].wb  = m[k].mem;
        m[k].mem = m[k].ex;
        if (r.bubble) begin
            m[k].ex    = BNOP;
            m[k].ex_rt = '0;
            m[k].owed  = r.owed - 1;
            if (m[k].ps < pmax[k]) m[k].ps++;
        end else begin
            m[k].ex    = ref_bundle(opcode, funct);
            m[k].ex_rt = rt;
            m[k].owed  = r.owed;
        end
        if (r.o[11] && m[k].pf < pmax[k]) m[k].pf++;
    endfunction

    task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] s,
                         input logic [4:0] t, input logic tk, input logic bz, input logic rsa);
        ev_t         r;
        logic [12:0] act;
        @(negedge clk);
        opcode = op; funct = fn; rs = s; rt = t; taken = tk; busy = bz;
        rst_n = !rsa; in_rst = rsa;
        if (rsa) begin
            model_reset(0);
            model_reset(1);
        end
        #1;
        for (int k = 0; k < 2; k++) begin
            r = ref_eval(k);
            act = (k == 0) ? out_a : out_b;
            check($sformatf("comb%0d", k), 32'(act[12:8]), 32'(r.o[12:8]));
            check($sformatf("pipe%0d", k), 32'(act[7:0]), 32'(r.o[7:0]));
        end
`ifdef CTRL_PERF_EN
        check("perf_stall0", 32'(a_ps), 32'(m[0].ps));
        check("perf_flush0", 32'(a_pf), 32'(m[0].pf));
        check("perf_stall1", 32'(b_ps), 32'(m[1].ps));
        check("perf_flush1", 32'(b_pf), 32'(m[1].pf));
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        if (!in_rst) begin
            model_advance(0);
            model_advance(1);
        end
    endtask

    task automatic do_reset();
        drive(O_BAD, 6'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        tick();
    endtask

    // ------------------------------------------------------------------
    // Directed table: one instruction per cycle, no register overlap.
    // ------------------------------------------------------------------
    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        logic       tk;
        logic [3:0] comb;   // {jump, jr, branch, flush}
        bun_t       b;
    } row_t;

    row_t tbl[13];

    initial begin
        int   sa, sb, ba, bb;
        bun_t e;
        logic [5:0] rop, rfn;
        int   sel;

        tbl[0]  = '{O_R,    F_ADD, 1'b0, 4'b0000, 8'b10_010010};
        tbl[1]  = '{O_R,    F_JR,  1'b0, 4'b0101, 8'b10_010000};
        tbl[2]  = '{O_ADDI, 6'd0,  1'b0, 4'b0000, 8'b00_100010};
        tbl[3]  = '{O_LW,   6'd0,  1'b0, 4'b0000, 8'b00_101011};
        tbl[4]  = '{O_SW,   6'd0,  1'b0, 4'b0000, 8'b00_100100};
        tbl[5]  = '{O_BGT,  6'd0,  1'b0, 4'b0010, 8'b01_000000};
        tbl[6]  = '{O_BGT,  6'd0,  1'b1, 4'b0011, 8'b01_000000};
        tbl[7]  = '{O_J,    6'd0,  1'b0, 4'b1001, 8'b11_000000};
        tbl[8]  = '{O_BAD,  6'd0,  1'b0, 4'b0000, 8'b11_000000};
        tbl[9]  = '{O_R,    6'd0,  1'b0, 4'b0000, 8'b10_010010};
        tbl[10] = '{O_BAD,  6'd0,  1'b0, 4'b0000, 8'b11_000000};
        tbl[11] = '{O_BAD,  6'd0,  1'b0, 4'b0000, 8'b11_000000};
        tbl[12] = '{O_BAD,  6'd0,  1'b0, 4'b0000, 8'b11_000000};

        // Reset state
        cur_tag = "reset";
        drive(O_BAD, 6'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        check("reset_out_a", 32'(out_a), 32'(13'b00000_11_000000));
        check("reset_out_b", 32'(out_b), 32'(13'b00000_11_000000));
        tick();

        // Decode table with pipeline latency checks
        cur_tag = "table";
        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].op, tbl[i].fn, 5'd0, 5'd0, tbl[i].tk, 1'b0, 1'b0);
            check($sformatf("comb_r%0d", i), 32'({a_jump, a_jr, a_br, a_flush}), 32'(tbl[i].comb));
            e = (i >= 1) ? tbl[i-1].b : BNOP;
            check($sformatf("ex_r%0d", i), 32'({a_alu, a_src, a_dst}), 32'({e.alu, e.src, e.dst}));
            e = (i >= 2) ? tbl[i-2].b : BNOP;
            check($sformatf("mem_r%0d", i), 32'({a_mr, a_mw}), 32'({e.mr, e.mw}));
            e = (i >= 3) ? tbl[i-3].b : BNOP;
            check($sformatf("wb_r%0d", i), 32'({a_rw, a_m2r}), 32'({e.rw, e.m2r}));
            tick();
        end

        // Load-use: LW r5 then ADD rs=5 held in ID
        cur_tag = "load_use";
        do_reset();
        drive(O_LW, 6'd0, 5'd0, 5'd5, 1'b0, 1'b0, 1'b0);
        tick();
        sa = 0; sb = 0; ba = 0; bb = 0;
        for (int c = 0; c < 6; c++) begin
            drive(O_R, F_ADD, 5'd5, 5'd2, 1'b0, 1'b0, 1'b0);
            sa += int'(a_stall); sb += int'(b_stall);
            ba += int'(a_alu == 2'b11); bb += int'(b_alu == 2'b11);
            if (c == 2) check("add_in_ex_a", 32'(a_alu), 32'(2'b10));
            if (c == 4) check("add_in_ex_b", 32'(b_alu), 32'(2'b10));
            tick();
        end
        check("stall_cycles_a", 32'(sa), 32'd1);
        check("stall_cycles_b", 32'(sb), 32'd3);
        check("bubbles_a", 32'(ba), 32'd1);
        check("bubbles_b", 32'(bb), 32'd3);

        // Load to r0 never stalls
        cur_tag = "load_r0";
        do_reset();
        drive(O_LW, 6'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        tick();
        drive(O_R, F_ADD, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        check("stall_a", 32'(a_stall), 32'd0);
        check("stall_b", 32'(b_stall), 32'd0);
        tick();

        // Reset in the middle of a multi-cycle stall
        cur_tag = "reset_mid";
        do_reset();
        drive(O_LW, 6'd0, 5'd0, 5'd5, 1'b0, 1'b0, 1'b0);
        tick();
        drive(O_R, F_ADD, 5'd5, 5'd2, 1'b0, 1'b0, 1'b0);
        check("pre_stall_b", 32'(b_stall), 32'd1);
        tick();
        drive(O_R, F_ADD, 5'd5, 5'd2, 1'b0, 1'b0, 1'b1);
        check("rst_stall_b", 32'(b_stall), 32'd0);
        check("rst_alu_b", 32'(b_alu), 32'(2'b11));
        tick();
        drive(O_R, F_ADD, 5'd5, 5'd2, 1'b0, 1'b0, 1'b0);
        check("post_stall_b", 32'(b_stall), 32'd0);
        check("post_alu_b", 32'(b_alu), 32'(2'b11));
        tick();

        // mem_busy freeze with a load-use pending
        cur_tag = "mem_busy";
        do_reset();
        drive(O_LW, 6'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0); tick();
        drive(O_SW, 6'd0, 5'd0, 5'd3, 1'b0, 1'b0, 1'b0); tick();
        drive(O_LW, 6'd0, 5'd0, 5'd5, 1'b0, 1'b0, 1'b0); tick();
        for (int c = 0; c < 4; c++) begin
            drive(O_J, 6'd0, 5'd5, 5'd2, 1'b0, 1'b1, 1'b0);
            check($sformatf("busy_stall_%0d", c), 32'(a_stall), 32'd1);
            check($sformatf("busy_flush_%0d", c), 32'(a_flush), 32'd0);
            check($sformatf("busy_pipe_%0d", c), 32'(out_a[7:0]), 32'(8'b00_100111));
            tick();
        end
        drive(O_J, 6'd0, 5'd5, 5'd2, 1'b0, 1'b0, 1'b0);
        check("release_haz_stall", 32'(a_stall), 32'd1);
        check("release_haz_flush", 32'(a_flush), 32'd0);
        tick();
        drive(O_J, 6'd0, 5'd5, 5'd2, 1'b0, 1'b0, 1'b0);
        check("after_bubble_stall", 32'(a_stall), 32'd0);
        check("after_bubble_flush", 32'(a_flush), 32'd1);
        tick();

        // Flush counter saturation
        cur_tag = "perf";
        do_reset();
        for (int c = 0; c < 5; c++) begin
            drive(O_J, 6'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
            tick();
        end
        drive(O_BAD, 6'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
`ifdef CTRL_PERF_EN
        check("flush_sat_a", 32'(a_pf), 32'd3);
        check("flush_cnt_b", 32'(b_pf), 32'd5);
`endif
        tick();

        // Random traffic against the model
        cur_tag = "random";
        do_reset();
        for (int n = 0; n < 400; n++) begin
            sel = int'($urandom_range(0, 7));
            case (sel)
                0:       rop = O_R;
                1:       rop = O_ADDI;
                2, 3:    rop = O_LW;
                4:       rop = O_SW;
                5:       rop = O_BGT;
                6:       rop = O_J;
                default: rop = 6'($urandom);
            endcase
            sel = int'($urandom_range(0, 3));
            case (sel)
                0:       rfn = F_ADD;
                1:       rfn = F_JR;
                2:       rfn = 6'd0;
                default: rfn = 6'($urandom);
            endcase
            drive(rop, rfn, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  1'($urandom), ($urandom_range(0, 4) == 0), ($urandom_range(0, 59) == 0));
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
